adc_scan_ctrl: RTL and testbench

- Parametrised successor to the single-shot serial ADC controller for the 8-channel ADC128S022-class converter.
- Scans a set of channels selected by a mask, in single-pass or continuous mode.
- Keeps CS low across a pass and handles the converter's one-frame address pipeline.
- Streams tagged results and also holds the latest result per channel in a readable register file.

---
 rtl/adc_scan_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_ctrl.sv
// Multi-channel scan controller for an 8-channel ADC128S022-class serial ADC.
// Runs back-to-back frames under one CS, tracks the one-frame address pipeline, streams and stores results.
module adc_scan_ctrl #(
    parameter int CLK_DIV = 13,
    parameter int NUM_CH  = 8,
    parameter int DATA_W  = 12
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Mode,
    input  logic [7:0]        Ch_mask,
    output logic              Busy,
    output logic              Data_valid,
    output logic [2:0]        Data_ch,
    output logic [DATA_W-1:0] Data_out,
    output logic              Scan_done,
    input  logic [2:0]        Rd_ch,
    output logic [DATA_W-1:0] Rd_data,
    output logic              ADC_CS,
    output logic              ADC_SCLK,
    output logic              ADC_DI,
    input  logic              ADC_DO
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] CH_EN    = 8'((9'd1 << NUM_CH) - 9'd1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    function automatic logic [2:0] first_ch(input logic [7:0] mask);
        first_ch = 3'd0;
        for (int i = 7; i >= 0; i--) if (mask[i]) first_ch = 3'(i);
    endfunction

    function automatic logic [2:0] last_ch(input logic [7:0] mask);
        last_ch = 3'd0;
        for (int i = 0; i < 8; i++) if (mask[i]) last_ch = 3'(i);
    endfunction

    // Next enabled channel after cur, wrapping; returns cur itself when it is the only one.
    function automatic logic [2:0] next_ch(input logic [7:0] mask, input logic [2:0] cur);
        logic [2:0] idx;
        next_ch = cur;
        for (int i = 7; i >= 1; i--) begin
            idx = cur + 3'(i);
            if (mask[idx]) next_ch = idx;
        end
    endfunction

    state_t            state, state_n;
    logic [7:0]        eff_mask, mask_r;
    logic              mode_r;
    logic [7:0]        div_cnt;
    logic              div_end;
    logic [3:0]        bit_cnt;
    logic [2:0]        next_addr, frame_addr, frame_data_ch, end_ch;
    logic              frame_has_data, not_first, flush, stop_req, deliver_pend;
    logic [15:0]       di_sr;
    logic [11:0]       shreg;
    logic [DATA_W-1:0] rf [8];
    logic              accept, frame_start, rise, fall, last_rise, is_last, stop_hit;

    assign eff_mask  = Ch_mask & CH_EN;
    assign div_end   = (div_cnt == DIV_LAST);
    assign end_ch    = last_ch(mask_r);
    assign last_rise = rise && (bit_cnt == 4'd15);
    assign is_last   = flush || (!mode_r && frame_has_data && frame_data_ch == end_ch);
    assign stop_hit  = Stop && (state == SHIFT) && !flush;
    assign Rd_data   = rf[Rd_ch];

    // NOTE: every output of an always_comb gets a default first, so no path leaves one unassigned and infers a latch.
    always_comb begin
        state_n     = state;
        accept      = 1'b0;
        frame_start = 1'b0;
        rise        = 1'b0;
        fall        = 1'b0;
        case (state)
            IDLE:  if (Start && eff_mask != 8'd0) begin
                       accept  = 1'b1;
                       state_n = SETUP;
                   end
            SETUP: if (div_end) begin
                       frame_start = 1'b1;
                       state_n     = SHIFT;
                   end
            SHIFT: if (div_end) begin
                       if (!ADC_SCLK) begin
                           rise = 1'b1;
                           if (bit_cnt == 4'd15 && is_last) state_n = HOLD;
                       end else if (bit_cnt == 4'd15) begin
                           frame_start = 1'b1;
                       end else begin
                           fall = 1'b1;
                       end
                   end
            HOLD:  if (div_end) state_n = GAP;
            GAP:   if (div_end) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_cnt        <= '0;
            bit_cnt        <= '0;
            mask_r         <= '0;
            mode_r         <= 1'b0;
            next_addr      <= '0;
            frame_addr     <= '0;
            frame_data_ch  <= '0;
            frame_has_data <= 1'b0;
            not_first      <= 1'b0;
            flush          <= 1'b0;
            stop_req       <= 1'b0;
            deliver_pend   <= 1'b0;
            di_sr          <= '0;
            shreg          <= '0;
            Busy           <= 1'b0;
            Data_valid     <= 1'b0;
            Data_ch        <= '0;
            Data_out       <= '0;
            Scan_done      <= 1'b0;
            ADC_CS         <= 1'b1;
            ADC_SCLK       <= 1'b1;
            ADC_DI         <= 1'b0;
        end else begin
            div_cnt <= (state == IDLE || div_end) ? 8'd0 : div_cnt + 8'd1;
            Busy    <= (state_n != IDLE);
            ADC_CS  <= !(state_n inside {SETUP, SHIFT, HOLD});

            if (accept) begin
                mask_r    <= eff_mask;
                mode_r    <= Mode;
                next_addr <= first_ch(eff_mask);
                not_first <= 1'b0;
                flush     <= 1'b0;
                stop_req  <= 1'b0;
            end

            // A Stop seen anywhere in a frame turns the following frame into the flush frame.
            if (frame_start) begin
                flush          <= stop_req || stop_hit;
                stop_req       <= 1'b0;
                frame_addr     <= next_addr;
                frame_data_ch  <= frame_addr;
                frame_has_data <= not_first;
                not_first      <= 1'b1;
                next_addr      <= next_ch(mask_r, next_addr);
                bit_cnt        <= 4'd0;
                ADC_SCLK       <= 1'b0;
                ADC_DI         <= 1'b0;
                di_sr          <= {2'b00, next_addr, 11'd0};
            end else if (stop_hit) begin
                stop_req <= 1'b1;
            end

            if (fall) begin
                bit_cnt  <= bit_cnt + 4'd1;
                ADC_SCLK <= 1'b0;
                ADC_DI   <= di_sr[14];
                di_sr    <= di_sr << 1;
            end

            if (rise) begin
                ADC_SCLK <= 1'b1;
                shreg    <= {shreg[10:0], ADC_DO};
            end

            deliver_pend <= last_rise && frame_has_data;
            Data_valid   <= deliver_pend;
            Scan_done    <= deliver_pend && (frame_data_ch == end_ch);
            if (deliver_pend) begin
                Data_ch  <= frame_data_ch;
                Data_out <= shreg[11 -: DATA_W];
            end
        end
    end

    // NOTE: the result store is reset explicitly because reads of never-scanned channels must return 0.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= '0;
        end else if (deliver_pend) begin
            rf[frame_data_ch] <= shreg[11 -: DATA_W];
        end
    end

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Directed bench for adc_scan_ctrl: a behavioural ADC128S022 model with address pipeline and delivery logging.
module tb_adc_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic       stop = 1'b0, mode = 1'b0;
    logic [7:0] ch_mask = 8'd0;
    logic [2:0] rd_ch = 3'd0;
    logic       adc_do = 1'b0;

    logic        busy0, dv0, sd0, cs0, sclk0, di0;
    logic [2:0]  dch0;
    logic [11:0] dout0, rd0;
    logic        busy1, dv1, sd1, cs1, sclk1, di1;
    logic [2:0]  dch1;
    logic [7:0]  dout1, rd1;
    logic        busy2, dv2, sd2, cs2, sclk2, di2;
    logic [2:0]  dch2;
    logic [11:0] dout2, rd2;

    always #5 clk = ~clk;

    adc_scan_ctrl u0 (
        .Clk(clk), .Rst_n(rst_n), .Start(start0), .Stop(stop), .Mode(mode), .Ch_mask(ch_mask),
        .Busy(busy0), .Data_valid(dv0), .Data_ch(dch0), .Data_out(dout0), .Scan_done(sd0),
        .Rd_ch(rd_ch), .Rd_data(rd0), .ADC_CS(cs0), .ADC_SCLK(sclk0), .ADC_DI(di0), .ADC_DO(adc_do)
    );

    adc_scan_ctrl #(.CLK_DIV(2), .NUM_CH(8), .DATA_W(8)) u1 (
        .Clk(clk), .Rst_n(rst_n), .Start(start1), .Stop(stop), .Mode(mode), .Ch_mask(ch_mask),
        .Busy(busy1), .Data_valid(dv1), .Data_ch(dch1), .Data_out(dout1), .Scan_done(sd1),
        .Rd_ch(rd_ch), .Rd_data(rd1), .ADC_CS(cs1), .ADC_SCLK(sclk1), .ADC_DI(di1), .ADC_DO(adc_do)
    );

    adc_scan_ctrl #(.CLK_DIV(2), .NUM_CH(4), .DATA_W(12)) u2 (
        .Clk(clk), .Rst_n(rst_n), .Start(start2), .Stop(stop), .Mode(mode), .Ch_mask(ch_mask),
        .Busy(busy2), .Data_valid(dv2), .Data_ch(dch2), .Data_out(dout2), .Scan_done(sd2),
        .Rd_ch(rd_ch), .Rd_data(rd2), .ADC_CS(cs2), .ADC_SCLK(sclk2), .ADC_DI(di2), .ADC_DO(adc_do)
    );

    // Only one instance is active at a time; the ADC model and monitor follow the selected one.
    int          sel = 0;
    logic        m_cs, m_sclk, m_di, m_busy, m_dv, m_sd;
    logic [2:0]  m_dch;
    logic [11:0] m_dout;

    always_comb begin
        m_cs = cs0; m_sclk = sclk0; m_di = di0; m_busy = busy0;
        m_dv = dv0; m_sd = sd0; m_dch = dch0; m_dout = dout0;
        if (sel == 1) begin
            m_cs = cs1; m_sclk = sclk1; m_di = di1; m_busy = busy1;
            m_dv = dv1; m_sd = sd1; m_dch = dch1; m_dout = 12'(dout1);
        end else if (sel == 2) begin
            m_cs = cs2; m_sclk = sclk2; m_di = di2; m_busy = busy2;
            m_dv = dv2; m_sd = sd2; m_dch = dch2; m_dout = dout2;
        end
    end

    logic [11:0] adc_val [8];
    logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0;
    int          m_period = 16, m_rise = 0;
    logic [15:0] m_word = '0;
    logic [2:0]  m_addr = '0, m_next_conv = '0;
    int          cyc = 0, n_rise = 0, cs_low_cnt = 0, n_done = 0, bad_done = 0;
    int          last_rise_cyc = 0, busy_fall_cyc = 0;
    int          dq[$], addr_log[$], exp_q[$], exp_addr[$];
    int          checks = 0, failures = 0;

    // Converter model: DO shifts on SCLK falls, DI address captured on rises 2..4, used by the next frame.
    always @(negedge clk) begin
        cyc++;
        if (!m_cs) cs_low_cnt++;
        if (!m_cs && prev_cs) begin
            m_period    = 16;
            m_next_conv = 3'd0;
        end
        if (!m_cs && prev_sclk && !m_sclk) begin
            if (m_period == 16) begin
                m_period = 0;
                m_rise   = 0;
                m_addr   = 3'd0;
                m_word   = {4'b0000, adc_val[m_next_conv]};
            end
            adc_do = m_word[15 - m_period];
            m_period++;
        end
        if (!m_cs && !prev_sclk && m_sclk) begin
            if (m_rise >= 2 && m_rise <= 4) m_addr = {m_addr[1:0], m_di};
            m_rise++;
            n_rise++;
            last_rise_cyc = cyc;
            if (m_rise == 16) begin
                m_next_conv = m_addr;
                addr_log.push_back(int'(m_addr));
            end
        end
        if (prev_busy && !m_busy) busy_fall_cyc = cyc;
        if (m_dv) dq.push_back(int'(m_dch) * 4096 + int'(m_dout));
        if (m_sd) begin
            n_done++;
            if (!m_dv) bad_done++;
        end
        prev_cs   = m_cs;
        prev_sclk = m_sclk;
        prev_busy = m_busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_logs(input string tag);
        check({tag, "_ndlv"}, dq.size(), exp_q.size());
        for (int i = 0; i < dq.size() && i < exp_q.size(); i++) check({tag, "_dlv"}, dq[i], exp_q[i]);
        if (exp_addr.size() != 0) begin
            check({tag, "_naddr"}, addr_log.size(), exp_addr.size());
            for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
                check({tag, "_addr"}, addr_log[i], exp_addr[i]);
        end
    endtask

    task automatic clear_logs();
        dq.delete(); addr_log.delete(); exp_q.delete(); exp_addr.delete();
        n_rise = 0; cs_low_cnt = 0; n_done = 0; bad_done = 0;
    endtask

    task automatic start_pulse(input int idx);
        @(negedge clk);
        if (idx == 0) start0 = 1'b1; else if (idx == 1) start1 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (m_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, m_busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        adc_val[0] = 12'h123; adc_val[1] = 12'h0B1; adc_val[2] = 12'hA5C; adc_val[3] = 12'h7E3;
        adc_val[4] = 12'h444; adc_val[5] = 12'h3F1; adc_val[6] = 12'h666; adc_val[7] = 12'hFFF;

        // Reset state
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cs", cs0, 1);
        check("rst_sclk", sclk0, 1);
        check("rst_di", di0, 0);
        check("rst_busy", busy0, 0);
        check("rst_valid", dv0, 0);
        check("rst_done", sd0, 0);
        check("rst_dch", dch0, 0);
        check("rst_dout", dout0, 0);
        for (int a = 0; a < 8; a++) begin
            rd_ch = 3'(a);
            #1 check("rst_rd", rd0, 0);
        end
        rd_ch = 3'd0;

        // Single pass over channels 2 and 5
        clear_logs();
        mode = 1'b0; ch_mask = 8'b0010_0100;
        start_pulse(0);
        wait_idle("pass", 3000);
        exp_q.push_back(2 * 4096 + 'hA5C); exp_q.push_back(5 * 4096 + 'h3F1);
        exp_addr.push_back(2); exp_addr.push_back(5); exp_addr.push_back(2);
        check_logs("pass");
        check("pass_cs_low", cs_low_cnt, 13 + 3 * 416);
        check("pass_rises", n_rise, 48);
        check("pass_ndone", n_done, 1);
        check("pass_done_align", bad_done, 0);
        check("pass_busy_tail", busy_fall_cyc - last_rise_cyc, 26);
        check("pass_hold_dch", dch0, 5);
        check("pass_hold_dout", dout0, 'h3F1);
        rd_ch = 3'd2;
        #1 check("pass_rd2", rd0, 'hA5C);

        // Rejected starts, simultaneous Start+Stop, Start while busy
        ch_mask = 8'd0;
        start_pulse(0);
        repeat (5) @(negedge clk);
        check("rej_zero_busy", busy0, 0);
        check("rej_zero_cs", cs0, 1);
        clear_logs();
        ch_mask = 8'h01;
        @(negedge clk);
        start0 = 1'b1; stop = 1'b1;
        @(negedge clk);
        start0 = 1'b0; stop = 1'b0;
        repeat (50) @(negedge clk);
        ch_mask = 8'hFF;
        start_pulse(0);
        check("rej_busy_cs", cs0, 0);
        wait_idle("rej", 3000);
        exp_q.push_back(0 * 4096 + 'h123);
        check_logs("rej");
        check("rej_rises", n_rise, 32);

        // Continuous scan over 0,1,3 with Stop in the middle of the second pass
        clear_logs();
        mode = 1'b1; ch_mask = 8'h0B;
        start_pulse(0);
        mode = 1'b0;
        repeat (1875) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_idle("cont", 5000);
        exp_q.push_back(0 * 4096 + 'h123); exp_q.push_back(1 * 4096 + 'h0B1);
        exp_q.push_back(3 * 4096 + 'h7E3); exp_q.push_back(0 * 4096 + 'h123);
        exp_q.push_back(1 * 4096 + 'h0B1);
        exp_addr.push_back(0); exp_addr.push_back(1); exp_addr.push_back(3);
        exp_addr.push_back(0); exp_addr.push_back(1); exp_addr.push_back(3);
        check_logs("cont");
        check("cont_rises", n_rise, 96);
        check("cont_ndone", n_done, 1);

        // NUM_CH=4: upper-channel mask ignored, mixed mask keeps channel 3 only
        sel = 2;
        ch_mask = 8'hF0; mode = 1'b0;
        start_pulse(2);
        repeat (5) @(negedge clk);
        check("n4_rej_busy", busy2, 0);
        check("n4_rej_cs", cs2, 1);
        clear_logs();
        ch_mask = 8'h18;
        start_pulse(2);
        check("n4_busy", busy2, 1);
        wait_idle("n4", 1000);
        exp_q.push_back(3 * 4096 + 'h7E3);
        check_logs("n4");
        check("n4_ndone", n_done, 1);

        // DATA_W=8: top bits of the conversion, register file holds the latest
        sel = 1;
        clear_logs();
        ch_mask = 8'h80;
        start_pulse(1);
        wait_idle("w8a", 1000);
        exp_q.push_back(7 * 4096 + 'hFF);
        check_logs("w8a");
        adc_val[7] = 12'h801;
        clear_logs();
        start_pulse(1);
        wait_idle("w8b", 1000);
        exp_q.push_back(7 * 4096 + 'h80);
        check_logs("w8b");
        rd_ch = 3'd7;
        #1 check("w8_rd7", rd1, 'h80);

        // Reset in the middle of a frame, then a normal scan
        sel = 0;
        ch_mask = 8'h04;
        start_pulse(0);
        repeat (212) @(negedge clk);
        rst_n = 1'b0;
        rd_ch = 3'd2;
        #1;
        check("mid_rst_cs", cs0, 1);
        check("mid_rst_sclk", sclk0, 1);
        check("mid_rst_di", di0, 0);
        check("mid_rst_busy", busy0, 0);
        check("mid_rst_dout", dout0, 0);
        check("mid_rst_rd2", rd0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        @(negedge clk);
        start_pulse(0);
        wait_idle("post_rst", 3000);
        exp_q.push_back(2 * 4096 + 'hA5C);
        check_logs("post_rst");
        #1 check("post_rst_rd2", rd0, 'hA5C);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
